// File: rtl/cpu_lsu_if.sv
// Memory bus between the load/store unit (master) and the core memory port (slave).
interface cpu_lsu_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_width;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ok;

    modport master (
        output mem_addr, mem_wdata, mem_width, mem_read, mem_write,
        input  mem_rdata, mem_ok
    );
    modport slave (
        input  mem_addr, mem_wdata, mem_width, mem_read, mem_write,
        output mem_rdata, mem_ok
    );
endinterface

// File: rtl/cpu_lsu.sv
// Multi-cycle ARMv4T load/store unit: single LDR/STR variants and LDM/STM block transfers.
// Define LSU_ALIGN_FAULT_EN to abort misaligned single accesses instead of rotating/forcing.
module cpu_lsu #(
    parameter int unsigned NREG        = 16,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_load,
    input  logic                    req_block,
    input  logic                    req_up,
    input  logic                    req_before,
    input  logic [1:0]              req_width,
    input  logic                    req_signed,
    input  logic [$clog2(NREG)-1:0] req_rd,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_wdata,
    input  logic [NREG-1:0]         req_reglist,
    output logic [$clog2(NREG)-1:0] rf_ridx,
    input  logic [31:0]             rf_rdata,
    output logic                    wb_valid,
    output logic [$clog2(NREG)-1:0] wb_idx,
    output logic [31:0]             wb_data,
    cpu_lsu_if.master               mem,
    output logic                    done,
    output logic [31:0]             base_out,
    output logic                    abort
);
    localparam int unsigned IDX_W = $clog2(NREG);
    localparam logic [31:0] TMO_LAST = 32'(MEM_TIMEOUT) - 32'd1;
`ifdef LSU_ALIGN_FAULT_EN
    localparam bit ALIGN_FAULT = 1'b1;
`else
    localparam bit ALIGN_FAULT = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SINGLE, S_BLOCK, S_DONE} state_t;

    state_t            state;
    logic              load_q;
    logic              signed_q;
    logic [1:0]        width_q;
    logic [1:0]        lane_q;
    logic [IDX_W-1:0]  rd_q;
    logic [31:0]       wdata_q;
    logic [NREG-1:0]   list_q;
    logic [IDX_W-1:0]  cur_q;
    logic [31:0]       base_fin_q;
    logic [31:0]       tmo_q;

    function automatic logic [31:0] popcount(input logic [NREG-1:0] l);
        popcount = '0;
        for (int i = 0; i < int'(NREG); i++) popcount = popcount + 32'(l[i]);
    endfunction

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NREG-1:0] l);
        lowest_idx = '0;
        for (int i = int'(NREG) - 1; i >= 0; i--) if (l[i]) lowest_idx = IDX_W'(i);
    endfunction

    // Block start/final addresses for the four LDM/STM modes
    logic [31:0] blk_n4, blk_start, blk_final;
    always_comb begin
        blk_n4    = popcount(req_reglist) << 2;
        blk_final = req_up ? req_addr + blk_n4 : req_addr - blk_n4;
        if (req_up) blk_start = req_before ? req_addr + 32'd4 : req_addr;
        else        blk_start = req_before ? req_addr - blk_n4 : req_addr - blk_n4 + 32'd4;
    end

    logic misalign;
    assign misalign = ((req_width == 2'd2) && (req_addr[1:0] != 2'b00)) ||
                      ((req_width == 2'd1) && req_addr[0]);

    logic [31:0] st_data;
    always_comb begin
        case (req_width)
            2'd0:    st_data = {4{req_wdata[7:0]}};
            2'd1:    st_data = {2{req_wdata[15:0]}};
            default: st_data = req_wdata;
        endcase
    end

    // Load formatting: word rotate for unaligned LDR, lane select plus extension for byte/half
    logic [4:0]  lane_sh;
    logic [31:0] rot;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_data;
    always_comb begin
        lane_sh = {lane_q, 3'b000};
        rot     = 32'({mem.mem_rdata, mem.mem_rdata} >> lane_sh);
        ld_b    = rot[7:0];
        ld_h    = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (width_q)
            2'd0:    ld_data = {{24{signed_q & ld_b[7]}}, ld_b};
            2'd1:    ld_data = {{16{signed_q & ld_h[15]}}, ld_h};
            default: ld_data = rot;
        endcase
    end

    logic            busy;
    logic            tmo_hit;
    logic [NREG-1:0] list_nx;
    assign busy     = (state == S_SINGLE) || (state == S_BLOCK);
    assign tmo_hit  = (MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST);
    assign list_nx  = list_q & ~(NREG'(1) << cur_q);

    // Writeback coincides with the completing mem_ok cycle
    assign wb_valid      = busy && mem.mem_ok && load_q;
    assign wb_idx        = wb_valid ? ((state == S_BLOCK) ? cur_q : rd_q) : '0;
    assign wb_data       = wb_valid ? ((state == S_BLOCK) ? mem.mem_rdata : ld_data) : '0;
    assign rf_ridx       = cur_q;
    assign mem.mem_wdata = !mem.mem_write ? '0 : ((state == S_BLOCK) ? rf_rdata : wdata_q);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= S_IDLE;
            req_ready     <= 1'b1;
            done          <= 1'b0;
            abort         <= 1'b0;
            base_out      <= '0;
            mem.mem_addr  <= '0;
            mem.mem_width <= 2'd2;
            mem.mem_read  <= 1'b0;
            mem.mem_write <= 1'b0;
            load_q        <= 1'b0;
            signed_q      <= 1'b0;
            width_q       <= 2'd2;
            lane_q        <= 2'b00;
            rd_q          <= '0;
            wdata_q       <= '0;
            list_q        <= '0;
            cur_q         <= '0;
            base_fin_q    <= '0;
            tmo_q         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        abort      <= 1'b0;
                        tmo_q      <= '0;
                        load_q     <= req_load;
                        signed_q   <= req_signed;
                        width_q    <= req_width;
                        lane_q     <= req_addr[1:0];
                        rd_q       <= req_rd;
                        wdata_q    <= st_data;
                        list_q     <= req_block ? req_reglist : '0;
                        cur_q      <= req_block ? lowest_idx(req_reglist) : '0;
                        base_fin_q <= blk_final;
                        if (!req_block) begin
                            if (ALIGN_FAULT && misalign) begin
                                state    <= S_DONE;
                                done     <= 1'b1;
                                abort    <= 1'b1;
                                base_out <= '0;
                            end else begin
                                state         <= S_SINGLE;
                                mem.mem_addr  <= (req_width == 2'd1) ? {req_addr[31:1], 1'b0} : req_addr;
                                mem.mem_width <= req_width;
                                mem.mem_read  <= req_load;
                                mem.mem_write <= !req_load;
                            end
                        end else if (req_reglist == '0) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            base_out <= req_addr;
                        end else begin
                            state         <= S_BLOCK;
                            mem.mem_addr  <= {blk_start[31:2], 2'b00};
                            mem.mem_width <= 2'd2;
                            mem.mem_read  <= req_load;
                            mem.mem_write <= !req_load;
                        end
                    end
                end
                S_SINGLE, S_BLOCK: begin
                    if (mem.mem_ok) begin
                        tmo_q  <= '0;
                        list_q <= list_nx;
                        cur_q  <= lowest_idx(list_nx);
                        if ((state == S_SINGLE) || (list_nx == '0)) begin
                            state         <= S_DONE;
                            done          <= 1'b1;
                            mem.mem_read  <= 1'b0;
                            mem.mem_write <= 1'b0;
                            mem.mem_width <= 2'd2;
                            base_out      <= (state == S_BLOCK) ? base_fin_q : '0;
                        end else begin
                            mem.mem_addr <= mem.mem_addr + 32'd4;
                        end
                    end else if (tmo_hit) begin
                        // Bus never answered: drop the request, keep earlier writebacks
                        state         <= S_DONE;
                        done          <= 1'b1;
                        abort         <= 1'b1;
                        mem.mem_read  <= 1'b0;
                        mem.mem_write <= 1'b0;
                        mem.mem_width <= 2'd2;
                        base_out      <= (state == S_BLOCK) ? base_fin_q : '0;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_lsu.sv
// Directed bench for cpu_lsu: single/block transfers, empty list, timeout, wrap and mid-op reset.
module tb_cpu_lsu;
    localparam int unsigned NREG  = 16;
    localparam int unsigned IDX_W = $clog2(NREG);

    logic             clk = 1'b0;
    logic             rstn;
    logic             req_valid, req_ready, req_load, req_block, req_up, req_before;
    logic [1:0]       req_width;
    logic             req_signed;
    logic [IDX_W-1:0] req_rd;
    logic [31:0]      req_addr, req_wdata;
    logic [NREG-1:0]  req_reglist;
    logic [IDX_W-1:0] rf_ridx;
    logic [31:0]      rf_rdata;
    logic             wb_valid;
    logic [IDX_W-1:0] wb_idx;
    logic [31:0]      wb_data;
    logic             done, abort;
    logic [31:0]      base_out;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int wb_cnt = 0;
    int wb0;

    logic [31:0] exp_a [3];
    logic [31:0] exp_d [3];

    cpu_lsu_if mem_bus();

    always #5 clk = ~clk;

    // Register file model: value identifies the register index
    assign rf_rdata = 32'hA5A5_0000 | 32'(rf_ridx);

    always @(posedge clk) if (wb_valid) wb_cnt <= wb_cnt + 1;

    cpu_lsu #(.NREG(NREG), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_block(req_block), .req_up(req_up), .req_before(req_before),
        .req_width(req_width), .req_signed(req_signed), .req_rd(req_rd),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_reglist(req_reglist),
        .rf_ridx(rf_ridx), .rf_rdata(rf_rdata),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .mem(mem_bus),
        .done(done), .base_out(base_out), .abort(abort)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents a request for one cycle; returns at the negedge after the accept edge
    task automatic issue(input logic ld, input logic blk, input logic up, input logic bef,
                         input logic [1:0] w, input logic sgn, input logic [IDX_W-1:0] rd,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [NREG-1:0] rl);
        req_load = ld; req_block = blk; req_up = up; req_before = bef;
        req_width = w; req_signed = sgn; req_rd = rd; req_addr = addr;
        req_wdata = wd; req_reglist = rl; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
    endtask

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_block = 1'b0; req_up = 1'b0;
        req_before = 1'b0; req_width = 2'd0; req_signed = 1'b0; req_rd = '0;
        req_addr = '0; req_wdata = '0; req_reglist = '0;
        mem_bus.mem_ok = 1'b0; mem_bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_width", mem_bus.mem_width, 2);
        chk("rst_read", mem_bus.mem_read, 0);
        chk("rst_done", done, 0);
        chk("rst_base", base_out, 0);
        rstn = 1'b1;

        // mem_ok while idle is ignored
        @(negedge clk);
        mem_bus.mem_ok = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF; #1;
        chk("idle_ok_wb", wb_valid, 0);
        @(negedge clk);
        mem_bus.mem_ok = 1'b0; #1;
        chk("idle_ok_done", done, 0);
        chk("idle_ok_ready", req_ready, 1);

        // LDR unaligned: rotate right by 16
        @(negedge clk);
        issue(1, 0, 0, 0, 2'd2, 0, 4'd5, 32'h0800_0002, 0, 0);
        chk("ldr_read", mem_bus.mem_read, 1);
        chk("ldr_addr", mem_bus.mem_addr, 32'h0800_0002);
        chk("ldr_ready", req_ready, 0);
        @(negedge clk); @(negedge clk);
        mem_bus.mem_ok = 1'b1; mem_bus.mem_rdata = 32'h1122_3344; #1;
        chk("ldr_wbv", wb_valid, 1);
        chk("ldr_wbidx", wb_idx, 5);
        chk("ldr_wbdata", wb_data, 32'h3344_1122);
        @(negedge clk);
        mem_bus.mem_ok = 1'b0; #1;
        chk("ldr_done", done, 1);
        chk("ldr_abort", abort, 0);
        chk("ldr_rd_drop", mem_bus.mem_read, 0);
        @(negedge clk); #1;
        chk("ldr_done_off", done, 0);
        chk("ldr_ready_back", req_ready, 1);

        // LDRSB byte 0x80
        issue(1, 0, 0, 0, 2'd0, 1, 4'd3, 32'h0000_0100, 0, 0);
        mem_bus.mem_ok = 1'b1; mem_bus.mem_rdata = 32'h1234_5680; #1;
        chk("ldrsb_data", wb_data, 32'hFFFF_FF80);
        chk("ldrsb_idx", wb_idx, 3);
        @(negedge clk);
        mem_bus.mem_ok = 1'b0; #1;
        chk("ldrsb_done", done, 1);
        @(negedge clk);

        // STRH replicated halfword at 0x202
        issue(0, 0, 0, 0, 2'd1, 0, 4'd0, 32'h0000_0202, 32'h0000_BEEF, 0);
        chk("strh_write", mem_bus.mem_write, 1);
        chk("strh_read", mem_bus.mem_read, 0);
        chk("strh_wdata", mem_bus.mem_wdata, 32'hBEEF_BEEF);
        chk("strh_width", mem_bus.mem_width, 1);
        chk("strh_addr", mem_bus.mem_addr, 32'h0000_0202);
        mem_bus.mem_ok = 1'b1; #1;
        chk("strh_nowb", wb_valid, 0);
        @(negedge clk);
        mem_bus.mem_ok = 1'b0; #1;
        chk("strh_done", done, 1);
        @(negedge clk);

        // STMDB base 0x3000 {r1,r2,r14}
        exp_a[0] = 32'h0000_2FF4; exp_a[1] = 32'h0000_2FF8; exp_a[2] = 32'h0000_2FFC;
        exp_d[0] = 32'hA5A5_0001; exp_d[1] = 32'hA5A5_0002; exp_d[2] = 32'hA5A5_000E;
        issue(0, 1, 0, 1, 2'd2, 0, 4'd0, 32'h0000_3000, 0, 16'h4006);
        for (int k = 0; k < 3; k++) begin
            chk("stm_write", mem_bus.mem_write, 1);
            chk("stm_addr", mem_bus.mem_addr, exp_a[k]);
            chk("stm_wdata", mem_bus.mem_wdata, exp_d[k]);
            mem_bus.mem_ok = 1'b1;
            @(negedge clk);
            mem_bus.mem_ok = 1'b0; #1;
        end
        chk("stm_done", done, 1);
        chk("stm_base", base_out, 32'h0000_2FF4);
        chk("stm_wr_drop", mem_bus.mem_write, 0);
        @(negedge clk);

        // LDMIA empty list: no bus access
        issue(1, 1, 1, 0, 2'd2, 0, 4'd0, 32'h0000_1000, 0, 16'h0000);
        chk("empty_done", done, 1);
        chk("empty_base", base_out, 32'h0000_1000);
        chk("empty_read", mem_bus.mem_read, 0);
        @(negedge clk); #1;
        chk("empty_ready", req_ready, 1);

        // LDMIB r0-r3 with beat 3 starved into timeout
        wb0 = wb_cnt;
        issue(1, 1, 1, 1, 2'd2, 0, 4'd0, 32'h0000_4000, 0, 16'h000F);
        chk("tmo_addr0", mem_bus.mem_addr, 32'h0000_4004);
        mem_bus.mem_ok = 1'b1; mem_bus.mem_rdata = 32'h1111_0000; #1;
        chk("tmo_wb0", wb_data, 32'h1111_0000);
        chk("tmo_idx0", wb_idx, 0);
        @(negedge clk);
        mem_bus.mem_ok = 1'b0; #1;
        chk("tmo_addr1", mem_bus.mem_addr, 32'h0000_4008);
        mem_bus.mem_ok = 1'b1; mem_bus.mem_rdata = 32'h2222_0001; #1;
        chk("tmo_wb1", wb_data, 32'h2222_0001);
        chk("tmo_idx1", wb_idx, 1);
        @(negedge clk);
        mem_bus.mem_ok = 1'b0; #1;
        chk("tmo_addr2", mem_bus.mem_addr, 32'h0000_400C);
        for (int i = 0; i < 8; i++) begin
            chk("tmo_stall", mem_bus.mem_read, 1);
            @(negedge clk); #1;
        end
        chk("tmo_done", done, 1);
        chk("tmo_abort", abort, 1);
        chk("tmo_rd_drop", mem_bus.mem_read, 0);
        chk("tmo_wbcount", 32'(wb_cnt - wb0), 2);
        @(negedge clk);

        // LDMIA wrapping past 0xFFFFFFFC
        issue(1, 1, 1, 0, 2'd2, 0, 4'd0, 32'hFFFF_FFFC, 0, 16'h0003);
        chk("wrap_addr0", mem_bus.mem_addr, 32'hFFFF_FFFC);
        mem_bus.mem_ok = 1'b1;
        @(negedge clk); #1;
        chk("wrap_addr1", mem_bus.mem_addr, 32'h0000_0000);
        @(negedge clk);
        mem_bus.mem_ok = 1'b0; #1;
        chk("wrap_done", done, 1);
        chk("wrap_base", base_out, 32'h0000_0004);
        chk("wrap_abort", abort, 0);
        @(negedge clk);

        // Reset during beat 2 of an LDM
        issue(1, 1, 1, 0, 2'd2, 0, 4'd0, 32'h0000_5000, 0, 16'h0003);
        mem_bus.mem_ok = 1'b1; mem_bus.mem_rdata = 32'h0000_0055;
        @(negedge clk);
        mem_bus.mem_ok = 1'b0; #1;
        chk("rstmid_beat2", mem_bus.mem_addr, 32'h0000_5004);
        rstn = 1'b0;
        @(negedge clk); #1;
        chk("rstmid_ready", req_ready, 1);
        chk("rstmid_read", mem_bus.mem_read, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_wb", wb_valid, 0);
        rstn = 1'b1;
        @(negedge clk); #1;
        chk("rstmid_nodone", done, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
